// File: rtl/jtkicker_pkg.sv
// Shared definitions for the Kicker sound latch: IRQ FSM encoding and status bit positions.
package jtkicker_pkg;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_t;

  localparam int STATUS_VALID   = 0;
  localparam int STATUS_OVERRUN = 1;

endpackage

// File: rtl/jtkicker_sndtimer.sv
// Free-running sound timer: a snd_cen prescaler of TIMER_DIV steps feeding a 4-bit counter.
module jtkicker_sndtimer #(
  parameter int TIMER_DIV = 1024
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       snd_cen,
  output logic [3:0] timer
);

  localparam int            PW   = $clog2(TIMER_DIV);
  localparam logic [PW-1:0] LAST = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      timer <= '0;
    end else if (snd_cen) begin
      if (presc == LAST) begin
        presc <= '0;
        timer <= timer + 4'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/jtkicker_sndlatch.sv
// Main-to-sound CPU latch with overrun status and a pending-IRQ FSM.
// Define JTKICKER_SND_TIMER_EN to include the free-running sound timer.
module jtkicker_sndlatch
  import jtkicker_pkg::*;
#(
  parameter int TIMER_DIV = 1024
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       main_cen,
  input  logic       main_rnw,
  input  logic [7:0] main_dout,
  input  logic       snd_data_cs,
  input  logic       snd_on_cs,
  input  logic       snd_cen,
  input  logic       latch_rd,
  input  logic       irq_ack,
  output logic [7:0] latch_dout,
  output logic       snd_irqn,
  output logic [1:0] status,
  output logic [3:0] timer
);

  logic       latch_wr;
  logic       irq_trig;
  logic       data_valid;
  logic       overrun;
  irq_state_t state, state_nxt;

  assign latch_wr = main_cen & snd_data_cs & ~main_rnw;
  assign irq_trig = main_cen & snd_on_cs   & ~main_rnw;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_dout <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (latch_wr) begin
      // A simultaneous read consumed the old byte, so it is not lost.
      latch_dout <= main_dout;
      overrun    <= data_valid & ~latch_rd;
      data_valid <= 1'b1;
    end else if (latch_rd) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IRQ_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assigned first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_IDLE: if (irq_trig)            state_nxt = IRQ_PEND;
      IRQ_PEND: if (irq_ack && !irq_trig) state_nxt = IRQ_IDLE;
      default:                           state_nxt = IRQ_IDLE;
    endcase
  end

  assign snd_irqn = (state != IRQ_PEND);

  assign status[STATUS_VALID]   = data_valid;
  assign status[STATUS_OVERRUN] = overrun;

`ifdef JTKICKER_SND_TIMER_EN
  jtkicker_sndtimer #(
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .rst     (rst),
    .clk     (clk),
    .snd_cen (snd_cen),
    .timer   (timer)
  );
`else
  logic unused_timer;
  assign unused_timer = snd_cen ^ TIMER_DIV[0];
  assign timer        = 4'd0;
`endif

endmodule

// File: tb/tb_jtkicker_sndlatch.sv
// Self-checking bench for jtkicker_sndlatch: vector table with scoreboard, async reset and timer sequences.
module tb_jtkicker_sndlatch;
  import jtkicker_pkg::*;

  logic       rst, clk;
  logic       main_cen, main_rnw;
  logic [7:0] main_dout;
  logic       snd_data_cs, snd_on_cs, snd_cen, latch_rd, irq_ack;
  logic [7:0] latch_dout;
  logic       snd_irqn;
  logic [1:0] status;
  logic [3:0] timer;

  int checks = 0;
  int errors = 0;

  jtkicker_sndlatch #(.TIMER_DIV(4)) dut (
    .rst         (rst),
    .clk         (clk),
    .main_cen    (main_cen),
    .main_rnw    (main_rnw),
    .main_dout   (main_dout),
    .snd_data_cs (snd_data_cs),
    .snd_on_cs   (snd_on_cs),
    .snd_cen     (snd_cen),
    .latch_rd    (latch_rd),
    .irq_ack     (irq_ack),
    .latch_dout  (latch_dout),
    .snd_irqn    (snd_irqn),
    .status      (status),
    .timer       (timer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic       rnw;
    logic       trig;
    logic       ack;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [1:0] exp_status;
    logic       exp_irqn;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic [1:0] status;
    logic       irqn;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic rnw, input logic trig,
                              input logic ack, input logic [7:0] din, input logic [7:0] edout,
                              input logic [1:0] estat, input logic eirqn);
    vec_t v;
    v.wr = wr; v.rd = rd; v.rnw = rnw; v.trig = trig; v.ack = ack; v.din = din;
    v.exp_dout = edout; v.exp_status = estat; v.exp_irqn = eirqn;
    return v;
  endfunction

  task automatic clear_inputs();
    main_cen = 1'b0; main_rnw = 1'b1; main_dout = 8'h00;
    snd_data_cs = 1'b0; snd_on_cs = 1'b0; latch_rd = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    main_cen    = v.wr | v.trig;
    snd_data_cs = v.wr;
    snd_on_cs   = v.trig;
    main_rnw    = v.rnw;
    main_dout   = v.din;
    latch_rd    = v.rd;
    irq_ack     = v.ack;
    sb.push_back('{v.exp_dout, v.exp_status, v.exp_irqn});
    @(posedge clk);
    #1;
    clear_inputs();
    e = sb.pop_front();
    check($sformatf("vec%0d latch_dout", idx), 32'(latch_dout), 32'(e.dout));
    check($sformatf("vec%0d status", idx),     32'(status),     32'(e.status));
    check($sformatf("vec%0d snd_irqn", idx),   32'(snd_irqn),   32'(e.irqn));
  endtask

  initial begin
    int exp_t4;
    rst = 1'b1;
    snd_cen = 1'b0;
    clear_inputs();

    //        wr rd rnw trig ack din    dout   stat  irqn
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 2'b00, 1)); // idle after reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h5A, 8'h5A, 2'b01, 1)); // write 0x5A
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h5A, 2'b00, 1)); // read clears status
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h11, 8'h11, 2'b01, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h22, 8'h22, 2'b11, 1)); // overrun
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h22, 2'b00, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h33, 8'h33, 2'b01, 1)); // write wins over read
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h44, 8'h44, 2'b01, 1)); // write+read while valid: no overrun
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h99, 8'h44, 2'b01, 1)); // bus read on data select
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h44, 2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'hFF, 8'h44, 2'b00, 0)); // trigger, data ignored
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h44, 2'b00, 0)); // second trigger
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h44, 2'b00, 1)); // ack
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h44, 2'b00, 1)); // ack while idle
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 8'h44, 2'b00, 0)); // trigger+ack -> pend
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h44, 2'b00, 0)); // bus read on irq select
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h44, 2'b00, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h44, 2'b00, 1)); // bus read does not trigger
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h77, 8'h77, 2'b01, 0)); // write and trigger together

    #2;
    check("reset latch_dout", 32'(latch_dout), 32'h00);
    check("reset status",     32'(status),     32'h0);
    check("reset snd_irqn",   32'(snd_irqn),   32'h1);
    check("reset timer",      32'(timer),      32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    check("timer idle without snd_cen", 32'(timer), 32'h0);

    // Asynchronous reset mid-PEND with valid data, sampled between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst snd_irqn",   32'(snd_irqn),   32'h1);
    check("async rst status",     32'(status),     32'h0);
    check("async rst latch_dout", 32'(latch_dout), 32'h00);

    // Events presented while reset is held must be ignored
    main_cen = 1'b1; snd_data_cs = 1'b1; snd_on_cs = 1'b1; main_rnw = 1'b0; main_dout = 8'hC3;
    @(posedge clk);
    #1;
    clear_inputs();
    check("held rst latch_dout", 32'(latch_dout), 32'h00);
    check("held rst status",     32'(status),     32'h0);
    check("held rst snd_irqn",   32'(snd_irqn),   32'h1);

    // Timer: TIMER_DIV=4, snd_cen always high
    @(negedge clk);
    rst = 1'b0;
    snd_cen = 1'b1;
    check("timer start", 32'(timer), 32'h0);
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      #1;
`ifdef JTKICKER_SND_TIMER_EN
      exp_t4 = (k / 4) % 16;
`else
      exp_t4 = 0;
`endif
      check($sformatf("timer edge%0d", k), 32'(timer), 32'(exp_t4));
    end
    snd_cen = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
